// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_pkg
//  Description : Shared definitions for the sequential ALU. Holds the opcode
//                encodings, the opcode width and the control FSM state type.
//  Ports       : none (package)
//  Config      : SEQ_ALU_DIV_EN enables the divider in the importing modules
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_MULT = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b101;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b110;
    localparam logic [OP_W-1:0] OP_DIV  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_muldiv
//  Description : Iterative multiply / divide engine. MULT is shift-add and
//                DIV is restoring, one bit per cycle over WIDTH cycles, on
//                operand magnitudes; signs are re-applied as the last step
//                retires. done pulses in the cycle the final step happens,
//                with hi/lo/flags valid in that same cycle.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                start, is_div       - launch an operation / select DIV
//                unsig, a, b         - sign mode and operands
//                done                - final-step strobe, results valid
//                hi, lo              - product halves or remainder/quotient
//                overflow, div_zero  - DIV MIN/-1 and DIV by zero flags
//  Config      : SEQ_ALU_DIV_EN - include the restoring divider
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic             unsig,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             overflow,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;   // MULT: {partial, multiplier}; DIV: {rem, dividend/quotient}
    logic [WIDTH-1:0]   r_opnd;  // MULT: multiplicand; DIV: divisor
    logic               r_neg;   // operand signs differ: negate product / quotient

    logic               w_sa, w_sb, w_last;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_mul_next, w_step, w_prod;

    assign w_sa    = ~unsig & a[WIDTH-1];
    assign w_sb    = ~unsig & b[WIDTH-1];
    assign w_abs_a = w_sa ? -a : a;
    assign w_abs_b = w_sb ? -b : b;
    assign w_last  = (r_cnt == CW'(WIDTH-1));
    assign done    = r_busy & w_last;

    // Shift-add: carry out of the upper half lands in the top bit after the shift.
    assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg ? -w_step : w_step;

`ifdef SEQ_ALU_DIV_EN
    logic               r_is_div, r_neg_r, r_ovf, r_dz;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH:0]     w_shift, w_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_q, w_r;

    // Restoring step: remainder < divisor keeps the shifted value within WIDTH+1 bits.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_opnd};
    assign w_div_next = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
    assign w_step     = r_is_div ? w_div_next : w_mul_next;

    assign w_q = w_step[WIDTH-1:0];
    assign w_r = w_step[2*WIDTH-1:WIDTH];

    // Divide by zero overrides the iterated result with all-ones / dividend.
    assign lo = !r_is_div ? w_prod[WIDTH-1:0] :
                r_dz      ? '1 : (r_neg ? -w_q : w_q);
    assign hi = !r_is_div ? w_prod[2*WIDTH-1:WIDTH] :
                r_dz      ? r_a_raw : (r_neg_r ? -w_r : w_r);
    assign overflow = r_ovf;
    assign div_zero = r_dz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
            r_ovf    <= 1'b0;
            r_dz     <= 1'b0;
            r_a_raw  <= '0;
        end else if (start) begin
            r_is_div <= is_div;
            r_neg_r  <= w_sa;
            r_ovf    <= is_div & ~unsig & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (&b);
            r_dz     <= is_div & (b == '0);
            r_a_raw  <= a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (start) begin
            r_acc  <= {{WIDTH{1'b0}}, (is_div ? w_abs_a : w_abs_b)};
            r_opnd <= is_div ? w_abs_b : w_abs_a;
        end else if (r_busy) begin
            r_acc  <= w_step;
        end
    end
`else
    logic w_unused_div;
    assign w_unused_div = is_div;
    assign w_step   = w_mul_next;
    assign lo       = w_prod[WIDTH-1:0];
    assign hi       = w_prod[2*WIDTH-1:WIDTH];
    assign overflow = 1'b0;
    assign div_zero = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_opnd <= '0;
        end else if (start) begin
            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
            r_opnd <= w_abs_a;
        end else if (r_busy) begin
            r_acc  <= w_step;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_neg  <= w_sa ^ w_sb;
        end else if (r_busy) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Multi-cycle integer ALU with valid/ready handshakes. Logic,
//                ADD/SUB and compare complete in one cycle; MULT (and DIV when
//                enabled) run on the iterative engine. Results are held in
//                DONE until the consumer accepts them.
//  Ports       : clk, rst_n                  - clock, async active-low reset
//                in_valid, in_ready          - operand handshake
//                a, b, op, unsig             - operands, opcode, sign mode
//                out_valid, out_ready        - result handshake
//                result_lo, result_hi        - result halves
//                compout, overflow, div_zero, illegal - status flags
//  Config      : SEQ_ALU_DIV_EN - DIV datapath present; otherwise op 111
//                completes in one cycle as an illegal op
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             unsig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             compout,
    output logic             overflow,
    output logic             div_zero,
    output logic             illegal
);

    state_t           r_state, w_next;
    logic             w_accept, w_multi, w_is_div;
    logic             w_md_done, w_md_ovf, w_md_dz;
    logic [WIDTH-1:0] w_md_hi, w_md_lo;
    logic [WIDTH-1:0] w_sum, w_dif, w_lo;
    logic             w_lt, w_ovf, w_ill;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_ready & in_valid;
    assign w_is_div  = (op == OP_DIV);

`ifdef SEQ_ALU_DIV_EN
    assign w_multi = (op == OP_MULT) | w_is_div;
`else
    assign w_multi = (op == OP_MULT);
`endif

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_accept & w_multi),
        .is_div   (w_is_div),
        .unsig    (unsig),
        .a        (a),
        .b        (b),
        .done     (w_md_done),
        .hi       (w_md_hi),
        .lo       (w_md_lo),
        .overflow (w_md_ovf),
        .div_zero (w_md_dz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next = w_multi ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_md_done) w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Single-cycle datapath
    assign w_sum = a + b;
    assign w_dif = a - b;
    assign w_lt  = unsig ? (a < b) : ($signed(a) < $signed(b));

    always_comb begin
        w_lo  = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (op)
            OP_AND: w_lo = a & b;
            OP_OR:  w_lo = a | b;
            OP_NOR: w_lo = ~(a | b);
            OP_XOR: w_lo = a ^ b;
            OP_ADD: begin
                w_lo  = w_sum;
                w_ovf = ~unsig & (a[WIDTH-1] == b[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_lo  = w_dif;
                w_ovf = ~unsig & (a[WIDTH-1] != b[WIDTH-1]) & (w_dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_DIV: begin
`ifndef SEQ_ALU_DIV_EN
                w_ill = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Acceptance clears flags and captures compout for every op; multi-cycle
    // ops overwrite the result halves and DIV flags when the engine retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_lo <= '0;
            result_hi <= '0;
            compout   <= 1'b0;
            overflow  <= 1'b0;
            div_zero  <= 1'b0;
            illegal   <= 1'b0;
        end else if (w_accept) begin
            result_lo <= w_lo;
            result_hi <= '0;
            compout   <= w_lt;
            overflow  <= w_ovf;
            div_zero  <= 1'b0;
            illegal   <= w_ill;
        end else if ((r_state == ST_BUSY) && w_md_done) begin
            result_lo <= w_md_lo;
            result_hi <= w_md_hi;
            overflow  <= w_md_ovf;
            div_zero  <= w_md_dz;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed self-checking bench for seq_alu (WIDTH = 32).
//  Config      : SEQ_ALU_DIV_EN selects the DIV scenario variant
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         unsig = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, compout, overflow, div_zero, illegal;
    logic [W-1:0] result_lo, result_hi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .unsig     (unsig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .compout   (compout),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .illegal   (illegal)
    );

    // Drive one op from IDLE; lat = edges from acceptance until out_valid seen.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic u, output int lat);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; unsig = u;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (result_lo !== '0 || result_hi !== '0) begin errors++; $display("FAIL rst_results: got %h_%h want 0", result_hi, result_lo); end
        checks++; if ({compout, overflow, div_zero, illegal} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {compout, overflow, div_zero, illegal}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        int lat;
        issue(3'b010, 32'h7FFFFFFF, 32'h1, 1'b0, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
        checks++; if (result_lo !== 32'h80000000) begin errors++; $display("FAIL add_s_lo: got %h want 80000000", result_lo); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL add_s_ovf: got %b want 1", overflow); end
        checks++; if (result_hi !== '0) begin errors++; $display("FAIL add_s_hi: got %h want 0", result_hi); end
        consume();
        issue(3'b010, 32'h7FFFFFFF, 32'h1, 1'b1, lat);
        checks++; if (result_lo !== 32'h80000000) begin errors++; $display("FAIL add_u_lo: got %h want 80000000", result_lo); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL add_u_ovf: got %b want 0", overflow); end
        consume();
    endtask

    task automatic test_sub();
        int lat;
        issue(3'b110, 32'h1, 32'h2, 1'b0, lat);
        checks++; if (result_lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub_s_lo: got %h want ffffffff", result_lo); end
        checks++; if (compout !== 1'b1) begin errors++; $display("FAIL sub_s_comp: got %b want 1", compout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sub_s_ovf: got %b want 0", overflow); end
        consume();
        issue(3'b110, 32'hFFFFFFFF, 32'h1, 1'b1, lat);
        checks++; if (result_lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_u_lo: got %h want fffffffe", result_lo); end
        checks++; if (compout !== 1'b0) begin errors++; $display("FAIL sub_u_comp: got %b want 0", compout); end
        consume();
        issue(3'b110, 32'h80000000, 32'h1, 1'b0, lat);
        checks++; if (result_lo !== 32'h7FFFFFFF || overflow !== 1'b1) begin errors++; $display("FAIL sub_s_ovf_min: got %h ovf %b want 7fffffff ovf 1", result_lo, overflow); end
        consume();
    endtask

    task automatic test_logic();
        int lat;
        logic [2:0]   ops [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
        logic [W-1:0] exp [4] = '{32'h00F0000F, 32'hFFF00FFF, 32'h000FF000, 32'hFF000FF0};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], 32'hF0F000FF, 32'h0FF00F0F, 1'b0, lat);
            checks++; if (result_lo !== exp[i]) begin errors++; $display("FAIL logic_op%0d: got %h want %h", ops[i], result_lo, exp[i]); end
            consume();
        end
    endtask

    task automatic test_mult();
        int lat;
        issue(3'b011, 32'hFFFFFFFF, 32'h2, 1'b0, lat);
        checks++; if (lat != 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", lat); end
        checks++; if ({result_hi, result_lo} !== 64'hFFFFFFFF_FFFFFFFE) begin errors++; $display("FAIL mult_s: got %h_%h want ffffffff_fffffffe", result_hi, result_lo); end
        checks++; if (compout !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL mult_s_flags: got comp %b ovf %b want 1 0", compout, overflow); end
        consume();
        issue(3'b011, 32'hFFFFFFFF, 32'h2, 1'b1, lat);
        checks++; if ({result_hi, result_lo} !== 64'h00000001_FFFFFFFE) begin errors++; $display("FAIL mult_u: got %h_%h want 00000001_fffffffe", result_hi, result_lo); end
        checks++; if (lat != 33) begin errors++; $display("FAIL mult_u_latency: got %0d want 33", lat); end
        consume();
        issue(3'b011, 32'hFFFFFFFD, 32'h5, 1'b0, lat);
        checks++; if ({result_hi, result_lo} !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_neg3x5: got %h_%h want ffffffff_fffffff1", result_hi, result_lo); end
        consume();
        issue(3'b011, 32'h12345678, 32'h00010000, 1'b1, lat);
        checks++; if ({result_hi, result_lo} !== 64'h00001234_56780000) begin errors++; $display("FAIL mult_shift16: got %h_%h want 00001234_56780000", result_hi, result_lo); end
        consume();
    endtask

    task automatic test_div();
        int lat;
`ifdef SEQ_ALU_DIV_EN
        issue(3'b111, 32'hFFFFFFF9, 32'h2, 1'b0, lat);
        checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
        checks++; if (result_lo !== 32'hFFFFFFFD || result_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_m7_2: got q %h r %h want fffffffd ffffffff", result_lo, result_hi); end
        consume();
        issue(3'b111, 32'h80000000, 32'hFFFFFFFF, 1'b0, lat);
        checks++; if (result_lo !== 32'h80000000 || result_hi !== '0 || overflow !== 1'b1) begin errors++; $display("FAIL div_min_m1: got q %h r %h ovf %b want 80000000 0 1", result_lo, result_hi, overflow); end
        consume();
        issue(3'b111, 32'h12345678, 32'h0, 1'b0, lat);
        checks++; if (result_lo !== 32'hFFFFFFFF || result_hi !== 32'h12345678 || div_zero !== 1'b1) begin errors++; $display("FAIL div_zero: got q %h r %h dz %b want ffffffff 12345678 1", result_lo, result_hi, div_zero); end
        checks++; if (lat != 33) begin errors++; $display("FAIL div_zero_latency: got %0d want 33", lat); end
        consume();
        issue(3'b111, 32'd100, 32'd7, 1'b1, lat);
        checks++; if (result_lo !== 32'd14 || result_hi !== 32'd2 || div_zero !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL div_u_100_7: got q %h r %h dz %b ovf %b want e 2 0 0", result_lo, result_hi, div_zero, overflow); end
        consume();
`else
        issue(3'b111, 32'hFFFFFFF9, 32'h2, 1'b0, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL div_illegal_latency: got %0d want 1", lat); end
        checks++; if (illegal !== 1'b1 || result_lo !== '0 || result_hi !== '0) begin errors++; $display("FAIL div_illegal: got ill %b lo %h hi %h want 1 0 0", illegal, result_lo, result_hi); end
        checks++; if (div_zero !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL div_illegal_flags: got dz %b ovf %b want 0 0", div_zero, overflow); end
        consume();
`endif
        issue(3'b010, 32'd3, 32'd4, 1'b0, lat);
        checks++; if (illegal !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL flags_cleared: got ill %b dz %b want 0 0", illegal, div_zero); end
        consume();
    endtask

    task automatic test_hold();
        int lat;
        issue(3'b010, 32'd5, 32'd9, 1'b0, lat);
        @(negedge clk);
        in_valid = 1'b1; op = 3'b110; a = 32'd100; b = 32'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result_lo !== 32'd14 || compout !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid %b ready %b lo %h comp %b want 1 0 0000000e 1", i, out_valid, in_ready, result_lo, compout);
            end
        end
        in_valid = 1'b0;
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got valid %b ready %b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        @(negedge clk);
        in_valid = 1'b1; op = 3'b011; a = 32'd3; b = 32'd5; unsig = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        checks++; if (compout !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL busy_before_rst: got comp %b ready %b want 1 0", compout, in_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || result_lo !== '0 || result_hi !== '0 || {compout, overflow, div_zero, illegal} !== 4'b0) begin errors++; $display("FAIL busy_rst_outputs: got valid %b %h_%h flags %b want 0", out_valid, result_hi, result_lo, {compout, overflow, div_zero, illegal}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL busy_rst_ready: got %b want 1", in_ready); end
        issue(3'b010, 32'd3, 32'd4, 1'b0, lat);
        checks++; if (result_lo !== 32'd7 || lat != 1) begin errors++; $display("FAIL post_rst_add: got %h lat %0d want 7 lat 1", result_lo, lat); end
        consume();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_mult();
        test_div();
        test_hold();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
